// File: rtl/alu_op_driver.sv
// Sequential initiator for the 4-bit expanded ALU.
// Drives A/B/S, waits SETTLE cycles, captures Y, returns it via valid/ready.
module alu_op_driver #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [2:0]       rsp_op,
  output logic             rsp_zero,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_s;
  logic [WIDTH-1:0] r_y;
  logic [2:0]       r_op;
  logic             r_zero;
  logic             r_valid;

  logic w_idle;
  logic w_settle;
  logic w_resp;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_settle = (r_state == ST_SETTLE);
  assign w_resp   = (r_state == ST_RESP);

  assign req_ready = w_idle;
  assign busy      = !w_idle;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_s     = r_s;
  assign rsp_valid = r_valid;
  assign rsp_y     = r_y;
  assign rsp_op    = r_op;
  assign rsp_zero  = r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_y     <= '0;
      r_op    <= '0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        w_idle: begin
          if (req_valid) begin
            r_a     <= req_chain ? r_acc : req_a;
            r_b     <= req_b;
            r_s     <= req_op;
            r_cnt   <= CNT_INIT;
            r_state <= ST_SETTLE;
          end
        end
        w_settle: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // result comes only from the ALU, never recomputed here
            r_y     <= alu_y;
            r_acc   <= alu_y;
            r_op    <= r_s;
            r_zero  <= (alu_y == '0);
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        w_resp: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: behavioural ALU, response scoreboard,
// SETTLE=1 and SETTLE=3 instances.
module tb_alu_op_driver;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_valid3;
  logic [2:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_chain;
  logic       rsp_ready;
  logic       corrupt;

  logic       req_ready, rsp_valid, rsp_zero, busy;
  logic [3:0] alu_a, alu_b, alu_y, rsp_y;
  logic [2:0] alu_s, rsp_op;

  logic       req_ready3, rsp_valid3, rsp_zero3, busy3;
  logic [3:0] alu_a3, alu_b3, alu_y3, rsp_y3;
  logic [2:0] alu_s3, rsp_op3;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0] y;
    logic [2:0] op;
    logic       z;
  } exp_t;

  exp_t q[$];

  function automatic logic [3:0] alu(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] s
  );
    case (s)
      3'd0:    return ~a;
      3'd1:    return a | b;
      3'd2:    return a & b;
      3'd3:    return a ^ b;
      3'd4:    return a + b;
      3'd5:    return a + 4'd1;
      3'd6:    return a - b;
      default: return a - 4'd1;
    endcase
  endfunction

  assign alu_y  = alu(alu_a, alu_b, alu_s);
  assign alu_y3 = corrupt ? ~alu(alu_a3, alu_b3, alu_s3)
                          : alu(alu_a3, alu_b3, alu_s3);

  alu_op_driver #(.WIDTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_chain(req_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_op(rsp_op), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  alu_op_driver #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_chain(req_chain),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3), .alu_y(alu_y3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y3), .rsp_op(rsp_op3), .rsp_zero(rsp_zero3),
    .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // scoreboard: every completed handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp y=%h op=%h", rsp_y, rsp_op);
      end else begin
        e = q.pop_front();
        if ({rsp_y, rsp_op, rsp_zero} !== {e.y, e.op, e.z}) begin
          failures++;
          $display("FAIL rsp got y=%h op=%h z=%b exp y=%h op=%h z=%b",
                   rsp_y, rsp_op, rsp_zero, e.y, e.op, e.z);
        end
      end
    end
  end

  task automatic send(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ch,
    input logic       push,
    input logic [3:0] ey
  );
    int n;
    exp_t e;
    if (push) begin
      e.y  = ey;
      e.op = op;
      e.z  = (ey == 4'd0);
      q.push_back(e);
    end
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_chain = ch;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL send_timeout req_ready=%b exp 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0 || busy) begin
      failures++;
      $display("FAIL drain pending=%0d busy=%b exp 0 0", q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({alu_a, alu_b, alu_s, rsp_y, rsp_op, rsp_zero, rsp_valid, busy}
        !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs a=%h b=%h s=%h y=%h op=%h v=%b busy=%b exp 0",
               alu_a, alu_b, alu_s, rsp_y, rsp_op, rsp_valid, busy);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got %b exp 1", req_ready);
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bitwise();
    logic [3:0] exp_y[4];
    exp_y[0] = 4'b1001;
    exp_y[1] = 4'b1111;
    exp_y[2] = 4'b0100;
    exp_y[3] = 4'b1011;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(3'(i), 4'b0110, 4'b1101, 1'b0, 1'b1, exp_y[i]);
      @(negedge clk);
      checks++;
      if ({rsp_valid, alu_a, alu_b, alu_s} !== {1'b0, 4'b0110, 4'b1101, 3'(i)}) begin
        failures++;
        $display("FAIL bw_drive op=%0d v=%b a=%h b=%h s=%h exp 0 6 d %0d",
                 i, rsp_valid, alu_a, alu_b, alu_s, i);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL bw_valid_rise op=%0d got %b exp 1", i, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL bw_pulse_width op=%0d got %b exp 0", i, rsp_valid);
      end
    end
    wait_done();
  endtask

  task automatic test_arith();
    logic [3:0] exp_y[4];
    exp_y[0] = 4'd12;
    exp_y[1] = 4'd10;
    exp_y[2] = 4'd6;
    exp_y[3] = 4'd8;
    for (int i = 0; i < 4; i++)
      send(3'(4 + i), 4'd9, 4'd3, 1'b0, 1'b1, exp_y[i]);
    send(3'd6, 4'd3, 4'd9, 1'b0, 1'b1, 4'd10);
    wait_done();
  endtask

  task automatic test_chain();
    send(3'd7, 4'd1, 4'd0, 1'b0, 1'b1, 4'd0);
    send(3'd7, 4'd5, 4'd0, 1'b1, 1'b1, 4'd15);
    checks++;
    if (alu_a !== 4'd0) begin
      failures++;
      $display("FAIL chain_alu_a got %h exp 0", alu_a);
    end
    send(3'd5, 4'd7, 4'd0, 1'b1, 1'b1, 4'd0);
    checks++;
    if (alu_a !== 4'd15) begin
      failures++;
      $display("FAIL chain2_alu_a got %h exp f", alu_a);
    end
    wait_done();
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    send(3'd4, 4'd5, 4'd3, 1'b0, 1'b1, 4'd8);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_y, rsp_op, req_ready, busy} !== {1'b1, 4'd8, 3'd4, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL bp_hold c=%0d v=%b y=%h op=%h rdy=%b busy=%b exp 1 8 4 0 1",
                 i, rsp_valid, rsp_y, rsp_op, req_ready, busy);
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_y} !== {1'b1, 1'b0, 1'b0, 4'd8}) begin
      failures++;
      $display("FAIL bp_release rdy=%b busy=%b v=%b y=%h exp 1 0 0 8",
               req_ready, busy, rsp_valid, rsp_y);
    end
    wait_done();
  endtask

  task automatic test_settle3();
    @(negedge clk);
    #1;
    req_op     = 3'd4;
    req_a      = 4'd2;
    req_b      = 4'd5;
    req_chain  = 1'b0;
    req_valid3 = 1'b1;
    @(posedge clk);
    #1;
    req_valid3 = 1'b0;
    corrupt    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid3, alu_a3, alu_b3, alu_s3} !== {1'b0, 4'd2, 4'd5, 3'd4}) begin
        failures++;
        $display("FAIL s3_settle c=%0d v=%b a=%h b=%h s=%h exp 0 2 5 4",
                 i, rsp_valid3, alu_a3, alu_b3, alu_s3);
      end
    end
    corrupt = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid3, rsp_y3, rsp_op3, rsp_zero3} !== {1'b1, 4'd7, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL s3_capture v=%b y=%h op=%h z=%b exp 1 7 4 0",
               rsp_valid3, rsp_y3, rsp_op3, rsp_zero3);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid3, req_ready3} !== 2'b01) begin
      failures++;
      $display("FAIL s3_done v=%b rdy=%b exp 0 1", rsp_valid3, req_ready3);
    end
  endtask

  task automatic test_reset_midop();
    send(3'd4, 4'd6, 4'd1, 1'b0, 1'b0, 4'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_s, rsp_y, rsp_op, rsp_zero, rsp_valid, busy}
        !== 22'd0) begin
      failures++;
      $display("FAIL midop_reset a=%h b=%h s=%h y=%h v=%b busy=%b exp 0",
               alu_a, alu_b, alu_s, rsp_y, rsp_valid, busy);
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL midop_no_rsp c=%0d v=%b busy=%b exp 0 0",
                 i, rsp_valid, busy);
      end
    end
    send(3'd5, 4'd9, 4'd0, 1'b1, 1'b1, 4'd1);
    checks++;
    if (alu_a !== 4'd0) begin
      failures++;
      $display("FAIL midop_chain_a got %h exp 0", alu_a);
    end
    wait_done();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_op     = 3'd0;
    req_a      = 4'd0;
    req_b      = 4'd0;
    req_chain  = 1'b0;
    rsp_ready  = 1'b1;
    corrupt    = 1'b0;
    test_reset();
    test_bitwise();
    test_arith();
    test_chain();
    test_backpressure();
    test_settle3();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
Sequential initiator for the combinational 4-bit expanded ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's A/B/S inputs. After a programmable settle time it captures Y and returns the result with a zero flag over a second valid/ready handshake. An internal accumulator allows chained operations, where the previous result becomes the next A operand.

Parameters:
WIDTH, 4, operand/result width; must match the ALU datapath.
SETTLE, 1, cycles alu_* are held stable before Y is captured; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  driver can accept a request
req_op  in  3  ALU select code
req_a  in  WIDTH  operand A; ignored when req_chain=1
req_b  in  WIDTH  operand B
req_chain  in  1  1: use accumulator as A
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_s  out  3  to ALU S
alu_y  in  WIDTH  from ALU Y
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_y  out  WIDTH  captured result
rsp_op  out  3  op code that produced rsp_y
rsp_zero  out  1  rsp_y == 0
busy  out  1  state != IDLE

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n=0, all of the following are 0: alu_a, alu_b, alu_s, rsp_y, rsp_op, rsp_zero, rsp_valid, busy, accumulator, settle counter. The state is IDLE.
- req_ready is 1 exactly in IDLE and is combinational from the state only.
- ALU op encoding (mod 2^WIDTH, no carry out):
  - 000 = NOT A
  - 001 = A OR B
  - 010 = A AND B
  - 011 = A XOR B
  - 100 = A+B
  - 101 = A+1
  - 110 = A-B
  - 111 = A-1
- The driver never computes results itself; rsp_y is always the sampled alu_y.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - On req_valid & req_ready, register alu_a <= (req_chain ? acc : req_a), alu_b <= req_b, alu_s <= req_op, cnt <= SETTLE-1, then go to SETTLE.
  - Without req_valid, stay in IDLE. alu_* keep their last values; they do not return to 0.
- SETTLE:
  - If cnt != 0, decrement cnt and stay.
  - If cnt == 0, capture rsp_y <= alu_y, acc <= alu_y, rsp_op <= alu_s, rsp_zero <= (alu_y==0), set rsp_valid <= 1, and go to RESP.
  - Request inputs are ignored.
- RESP:
  - rsp_valid=1; rsp_y, rsp_op and rsp_zero are held stable.
  - On rsp_ready=1, clear rsp_valid and go to IDLE.
  - The next request can be accepted no earlier than the following cycle. No overlap: req_ready=0 throughout RESP, even when rsp_ready=1 in the same cycle.
- Latency: rsp_valid rises on the SETTLE-th rising edge after the accepting edge. The minimum request-to-request period is SETTLE+2 cycles when rsp_ready is held at 1.
- rsp_y and acc keep their values after the response handshake until the next capture.
- A chained request after reset uses acc=0.
- Reset asserted in any state aborts the operation immediately. No response is issued for the in-flight request, and acc clears.
- req_op values are all legal; there is no error path.

Test Plan:
- Bitwise sweep, SETTLE=1, rsp_ready=1:
  - A=0110, B=1101, ops 000..011 -> rsp_y = 1001, 1111, 0100, 1011.
  - Each rsp_valid pulse is 1 cycle wide and 1 edge after acceptance.
  - rsp_op echoes the request op.
- Arithmetic with wrap, A=9, B=3: ops 100..111 -> 12, 10, 6, 8. Then A=3, B=9, op 110 -> 10 (wrap), rsp_zero=0.
- Zero flag and chain:
  - A=1, op 111 -> 0 with rsp_zero=1.
  - Then chained op 111 -> 15 (alu_a driven as 0).
  - Then chained op 101 -> 0 with rsp_zero=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_y and rsp_op stay stable, req_ready=0, busy=1.
  - Release -> IDLE next cycle and req_ready=1.
- SETTLE=3 build: request accepted at edge t -> alu_* stable from t, rsp_valid first high after edge t+3. Changing alu_y before t+3 does not affect rsp_y.
- Reset mid-op: assert rst_n=0 asynchronously during SETTLE -> all outputs 0 immediately, no rsp_valid after release, and the first chained request uses A=0.
